// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU definitions: instruction width, halt opcode and
//               the instruction-memory loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int INSTR_WIDTH = 16;

  // Halt instruction; the loader uses the same value as its end-of-program mark.
  localparam logic [INSTR_WIDTH-1:0] HALT_INSTR = 16'hFFFF;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_HI    = 3'd1,
    LD_LO    = 3'd2,
    LD_WRITE = 3'd3,
    LD_DONE  = 3'd4,
    LD_ERR   = 3'd5
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Fills instruction memory from a byte stream. Big-endian byte
//               pairs become 16-bit words written to sequential addresses
//               from 0; the CPU is held until the terminator word is written.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import cpu_pkg::*;
#(
  parameter int                     ADDR_WIDTH = 8,
  parameter int                     DEPTH      = 256,
  parameter logic [INSTR_WIDTH-1:0] TERMINATOR = HALT_INSTR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   imem_we,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   error,
  output logic [ADDR_WIDTH:0]    word_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   ONE_WORD  = (ADDR_WIDTH + 1)'(1);

  loader_state_t state;

  // Load sequencer; every output is registered and derived from the next state,
  // so in_ready has no combinational dependency on in_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LD_IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        LD_IDLE: begin
          if (start) begin
            state      <= LD_HI;
            in_ready   <= 1'b1;
            imem_addr  <= '0;
            word_count <= '0;
          end
        end
        LD_HI: begin
          if (in_valid && in_ready) begin
            imem_wdata[15:8] <= in_data;
            state            <= LD_LO;
          end
        end
        LD_LO: begin
          // Low byte completes the word: write it in the very next cycle.
          if (in_valid && in_ready) begin
            imem_wdata[7:0] <= in_data;
            in_ready        <= 1'b0;
            imem_we         <= 1'b1;
            word_count      <= word_count + ONE_WORD;
            state           <= LD_WRITE;
          end
        end
        LD_WRITE: begin
          if (imem_wdata == TERMINATOR) begin
            state    <= LD_DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else if (imem_addr == LAST_ADDR) begin
            state <= LD_ERR;
            error <= 1'b1;
          end else begin
            imem_addr <= imem_addr + 1'b1;
            in_ready  <= 1'b1;
            state     <= LD_HI;
          end
        end
        LD_DONE, LD_ERR: begin
          if (start) begin
            state      <= LD_HI;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
            in_ready   <= 1'b1;
            imem_addr  <= '0;
            word_count <= '0;
          end
        end
        default: begin
          state    <= LD_IDLE;
          in_ready <= 1'b0;
          cpu_hold <= 1'b1;
          done     <= 1'b0;
          error    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
